// File: rtl/ifetch_queue.sv
// ifetch_queue: owns the fetch PC, issues word-aligned fetches (one outstanding), queues {inst, pc} for decode.
// Latency: redirect at edge N -> request in cycle N+1, response N+2, inst_valid N+3; 1 inst / 2 cycles steady state.
// Backpressure: inst_ready low fills the queue to DEPTH, then requests stop; a redirect flushes queue and in-flight fetch.
//
// Ports: clk/rst (sync, active-high); imem_req_* request channel (valid/ready, addr = fetch PC);
//        imem_resp_valid/data return path; redirect_valid/pc from branch logic; inst_valid/ready/data/pc to decode;
//        fetch_fault flags a misaligned redirect.
// Optional: define IFQ_ALIGN_CHECK_EN to fault and halt on misaligned redirects; otherwise redirect_pc[1:0] is
//           forced to 00 and fetch_fault is tied low.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HALT} state_t;

    state_t          state, state_nx;
    logic [31:0]     fetch_pc, pc_nx;
    logic [31:0]     req_pc, req_pc_nx;     // PC of the request currently outstanding
    logic [CW-1:0]   count, count_nx;
    logic [AW-1:0]   rd_ptr, rd_nx, wr_ptr, wr_nx;
    logic            pend, pend_nx;         // S_HALT still owes a response that must be swallowed
    logic            req_valid_q, inst_valid_q;
    logic [31:0]     inst_data_q, inst_pc_q;
    logic [31:0]     q_data [DEPTH];
    logic [31:0]     q_pc   [DEPTH];
    logic            wr_en, deq, req_hs, outstanding;
    logic [31:0]     redirect_eff, head_data_nx, head_pc_nx;

`ifdef IFQ_ALIGN_CHECK_EN
    logic            fault_q, fault_nx;
    assign redirect_eff = redirect_pc;
    assign fetch_fault  = fault_q;
`else
    assign redirect_eff = redirect_pc & ~32'h3;
    assign fetch_fault  = 1'b0;
`endif

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = fetch_pc;
    assign inst_valid     = inst_valid_q;
    assign inst_data      = inst_data_q;
    assign inst_pc        = inst_pc_q;

    assign deq    = inst_valid_q & inst_ready;
    assign req_hs = req_valid_q & imem_req_ready;
    // A response is still owed after this edge. A response arriving in the redirect cycle itself is
    // consumed (and discarded) right now, so it must not leave the FSM waiting for one that never comes.
    assign outstanding = req_hs |
                         (~imem_resp_valid & ((state == S_WAIT) | (state == S_DROP) | ((state == S_HALT) & pend)));

    always_comb begin
        state_nx  = state;
        pc_nx     = fetch_pc;
        req_pc_nx = req_pc;
        count_nx  = count;
        rd_nx     = rd_ptr;
        wr_nx     = wr_ptr;
        pend_nx   = pend;
        wr_en     = 1'b0;
`ifdef IFQ_ALIGN_CHECK_EN
        fault_nx  = fault_q;
`endif
        if (redirect_valid) begin
            // Flush wins over any same-cycle dequeue or enqueue.
            count_nx = '0;
            rd_nx    = '0;
            wr_nx    = '0;
            pc_nx    = redirect_eff;
            pend_nx  = 1'b0;
            state_nx = outstanding ? S_DROP : S_REQ;
`ifdef IFQ_ALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                state_nx = S_HALT;
                pend_nx  = outstanding;
                fault_nx = 1'b1;
            end else begin
                fault_nx = 1'b0;
            end
`endif
        end else begin
            case (state)
                S_REQ: begin
                    if (req_hs) begin
                        req_pc_nx = fetch_pc;
                        pc_nx     = fetch_pc + 32'd4;
                        state_nx  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A slot is guaranteed: the request was only issued while count < DEPTH.
                    if (imem_resp_valid) begin
                        wr_en    = 1'b1;
                        wr_nx    = wr_ptr + AW'(1);
                        state_nx = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_resp_valid) state_nx = S_REQ;
                end
                S_HALT: begin
                    if (imem_resp_valid) pend_nx = 1'b0;
                end
                default: state_nx = S_REQ;
            endcase
            if (deq) rd_nx = rd_ptr + AW'(1);
            count_nx = count + CW'(wr_en) - CW'(deq);
        end
        // Next head entry, with write-through when the new word lands directly at the head.
        head_data_nx = (wr_en && (wr_ptr == rd_nx)) ? imem_resp_data : q_data[rd_nx];
        head_pc_nx   = (wr_en && (wr_ptr == rd_nx)) ? req_pc         : q_pc[rd_nx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_REQ;
            fetch_pc     <= RESET_PC;
            req_pc       <= RESET_PC;
            count        <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            pend         <= 1'b0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_data_q  <= '0;
            inst_pc_q    <= '0;
`ifdef IFQ_ALIGN_CHECK_EN
            fault_q      <= 1'b0;
`endif
        end else begin
            state        <= state_nx;
            fetch_pc     <= pc_nx;
            req_pc       <= req_pc_nx;
            count        <= count_nx;
            rd_ptr       <= rd_nx;
            wr_ptr       <= wr_nx;
            pend         <= pend_nx;
            req_valid_q  <= (state_nx == S_REQ) && (count_nx < DEPTH_C);
            inst_valid_q <= (count_nx != '0);
            // Outputs hold their last value while the queue is empty.
            if (count_nx != '0) begin
                inst_data_q <= head_data_nx;
                inst_pc_q   <= head_pc_nx;
            end
            if (wr_en) begin
                q_data[wr_ptr] <= imem_resp_data;
                q_pc[wr_ptr]   <= req_pc;
            end
`ifdef IFQ_ALIGN_CHECK_EN
            fault_q      <= fault_nx;
`endif
        end
    end
endmodule
